// File: rtl/fmc_i2c_init_sequencer.sv
// FMC424 bring-up sequencer: walks a fixed table of I2C register writes through the byte-level master.
// Optional retry on NACK/timeout is compiled in with FMC_I2C_SEQ_RETRY_EN.
module fmc_i2c_init_sequencer #(
    parameter int NUM_ENTRIES = 2,
    parameter logic [NUM_ENTRIES*23-1:0] INIT_TABLE = {23'h3E_02_01, 23'h3E_02_00},
    parameter int GAP_CYCLES = 1000,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int MAX_RETRIES = 3,
    localparam int IDX_W = $clog2(NUM_ENTRIES + 1)
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [IDX_W-1:0] err_idx,
    output logic [1:0]       err_code,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [6:0]       cmd_addr,
    output logic [7:0]       cmd_reg,
    output logic [7:0]       cmd_data,
    input  logic             resp_valid,
    input  logic             resp_nack
);

    localparam int ENTRY_W = 23;
    localparam int TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GAP_W   = $clog2(GAP_CYCLES + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = {TMO_W{1'b1}};
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    localparam logic [1:0] CODE_NONE = 2'b00;
    localparam logic [1:0] CODE_NACK = 2'b01;
    localparam logic [1:0] CODE_TMO  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT_RESP,
        S_GAP,
        S_DONE,
        S_ERROR
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [6:0]         cmd_addr_q, cmd_addr_d;
    logic [7:0]         cmd_reg_q, cmd_reg_d;
    logic [7:0]         cmd_data_q, cmd_data_d;
    logic [IDX_W-1:0]   err_idx_q, err_idx_d;
    logic [1:0]         err_code_q, err_code_d;
    logic [ENTRY_W-1:0] entry;
    logic               fail;
    logic [1:0]         fail_code;
`ifdef FMC_I2C_SEQ_RETRY_EN
    localparam int RTY_W = $clog2(MAX_RETRIES + 1);
    logic [RTY_W-1:0]   retry_cnt_q, retry_cnt_d;
`endif

    // Constant-index mux keeps the lookup width-clean for any table size.
    always_comb begin
        entry = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (idx_q == IDX_W'(i)) entry = INIT_TABLE[i*ENTRY_W +: ENTRY_W];
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tmo_cnt_d  = tmo_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        cmd_addr_d = cmd_addr_q;
        cmd_reg_d  = cmd_reg_q;
        cmd_data_d = cmd_data_q;
        err_idx_d  = err_idx_q;
        err_code_d = err_code_q;
        fail       = 1'b0;
        fail_code  = CODE_NONE;
`ifdef FMC_I2C_SEQ_RETRY_EN
        retry_cnt_d = retry_cnt_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d    = S_LOAD;
                    idx_d      = '0;
                    err_idx_d  = '0;
                    err_code_d = CODE_NONE;
`ifdef FMC_I2C_SEQ_RETRY_EN
                    retry_cnt_d = '0;
`endif
                end
            end
            S_LOAD: begin
                cmd_addr_d = entry[22:16];
                cmd_reg_d  = entry[15:8];
                cmd_data_d = entry[7:0];
                state_d    = S_ISSUE;
            end
            S_ISSUE: begin
                if (cmd_ready) begin
                    state_d   = S_WAIT_RESP;
                    tmo_cnt_d = '0;
                end
            end
            S_WAIT_RESP: begin
                if (tmo_cnt_q != TMO_MAX) tmo_cnt_d = tmo_cnt_q + 1'b1;
                // A response landing on the timeout cycle takes priority.
                if (resp_valid) begin
                    if (resp_nack) begin
                        fail      = 1'b1;
                        fail_code = CODE_NACK;
                    end else begin
`ifdef FMC_I2C_SEQ_RETRY_EN
                        retry_cnt_d = '0;
`endif
                        if (idx_q == LAST_IDX) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d     = idx_q + 1'b1;
                            gap_cnt_d = '0;
                            state_d   = S_GAP;
                        end
                    end
                end else if (tmo_cnt_q == TMO_LAST) begin
                    fail      = 1'b1;
                    fail_code = CODE_TMO;
                end
                if (fail) begin
`ifdef FMC_I2C_SEQ_RETRY_EN
                    if (retry_cnt_q < RTY_W'(MAX_RETRIES)) begin
                        retry_cnt_d = retry_cnt_q + 1'b1;
                        gap_cnt_d   = '0;
                        state_d     = S_GAP;
                    end else begin
                        state_d    = S_ERROR;
                        err_idx_d  = idx_q;
                        err_code_d = fail_code;
                    end
`else
                    state_d    = S_ERROR;
                    err_idx_d  = idx_q;
                    err_code_d = fail_code;
`endif
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) state_d = S_LOAD;
                else gap_cnt_d = gap_cnt_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            tmo_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            cmd_addr_q <= '0;
            cmd_reg_q  <= '0;
            cmd_data_q <= '0;
            err_idx_q  <= '0;
            err_code_q <= CODE_NONE;
`ifdef FMC_I2C_SEQ_RETRY_EN
            retry_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tmo_cnt_q  <= tmo_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            cmd_addr_q <= cmd_addr_d;
            cmd_reg_q  <= cmd_reg_d;
            cmd_data_q <= cmd_data_d;
            err_idx_q  <= err_idx_d;
            err_code_q <= err_code_d;
`ifdef FMC_I2C_SEQ_RETRY_EN
            retry_cnt_q <= retry_cnt_d;
`endif
        end
    end

    assign busy      = (state_q == S_LOAD) || (state_q == S_ISSUE) ||
                       (state_q == S_WAIT_RESP) || (state_q == S_GAP);
    assign done      = (state_q == S_DONE);
    assign error     = (state_q == S_ERROR);
    assign cmd_valid = (state_q == S_ISSUE);
    assign cmd_addr  = cmd_addr_q;
    assign cmd_reg   = cmd_reg_q;
    assign cmd_data  = cmd_data_q;
    assign err_idx   = err_idx_q;
    assign err_code  = err_code_q;

endmodule
